dmem_lsu: RTL and testbench

Load/store unit and data memory for the processor, sitting directly downstream of the execute stage. It takes the ALU result as the effective address, plus rs2 data and the control stage's memren/memwren/funct3. It performs byte/half/word accesses against an internal byte-addressable array with a fixed, parameterised access latency. It returns the sign- or zero-extended load value to the writeback mux through a valid/ready handshake.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_lsu.sv | 168 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0100_0000;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Byte-addressed storage: four byte lanes at off..off+3, wrapping at the array end.
module dmem_array #(
    parameter int unsigned MEM_BYTES = 1048576,
    parameter int unsigned OFFW      = $clog2(MEM_BYTES)
) (
    input  logic            clk,
    input  logic [OFFW-1:0] off,
    input  logic [3:0]      we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata_c
);

    logic [7:0]      mem [MEM_BYTES];
    logic [OFFW-1:0] lane_off [4];

    // Lane addresses wrap naturally through the OFFW-bit add.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_off[i] = off + OFFW'(i);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[lane_off[i]] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rdata_c[8*i +: 8] = mem[lane_off[i]];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit with fixed-latency access to an internal data array.
// Optional macro MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned       AWIDTH    = 32,
    parameter int unsigned       DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(DEF_BASE_ADDR),
    parameter int unsigned       MEM_BYTES = 1048576,
    parameter int unsigned       LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic [2:0]        funct3_i,
    output logic              resp_valid_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              misalign_o
);

    localparam int unsigned OFFW = $clog2(MEM_BYTES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AWIDTH-1:0]  addr_q;
    logic [DWIDTH-1:0]  wdata_q;
    logic [2:0]         f3_q;
    logic               store_q;

    logic               hs_c;
    logic               latch_c;
    logic               access_c;
    logic               mis_c;
    logic [3:0]         be_c;
    logic [3:0]         we_c;
    logic [31:0]        rdata_c;
    logic [31:0]        ext_c;
    logic [AWIDTH-1:0]  off_full_c;
    logic [OFFW-1:0]    off_c;
    logic               unused_off_hi;

    assign hs_c          = req_valid_i && (memren_i || memwren_i);
    assign off_full_c    = addr_q - BASE_ADDR;
    assign off_c         = off_full_c[OFFW-1:0];
    assign unused_off_hi = ^off_full_c[AWIDTH-1:OFFW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs_c) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        latch_c  = 1'b0;
        access_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs_c) begin
                    latch_c = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        mis_c = 1'b0;
        case (f3_q)
            F3_LH:   mis_c = addr_q[0];
            F3_LHU:  mis_c = !store_q && addr_q[0];
            F3_LW:   mis_c = |addr_q[1:0];
            default: mis_c = 1'b0;
        endcase
    end
`else
    assign mis_c = 1'b0;
`endif

    always_comb begin
        case (f3_q)
            F3_SB:   be_c = 4'b0001;
            F3_SH:   be_c = 4'b0011;
            F3_SW:   be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
    end

    // A reset on the commit edge must suppress the write.
    assign we_c = (access_c && store_q && !mis_c && !rst) ? be_c : 4'b0000;

    always_comb begin
        case (f3_q)
            F3_LB:   ext_c = {{24{rdata_c[7]}}, rdata_c[7:0]};
            F3_LH:   ext_c = {{16{rdata_c[15]}}, rdata_c[15:0]};
            F3_LW:   ext_c = rdata_c;
            F3_LBU:  ext_c = {24'h0, rdata_c[7:0]};
            F3_LHU:  ext_c = {16'h0, rdata_c[15:0]};
            default: ext_c = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            data_o       <= '0;
            misalign_o   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            req_ready_o  <= (state_d == IDLE);
            resp_valid_o <= (state_d == RESP);
            if (access_c) begin
                data_o     <= (store_q || mis_c) ? '0 : DWIDTH'(ext_c);
                misalign_o <= mis_c;
            end
        end
    end

    // Request capture; no reset needed for the datapath.
    always_ff @(posedge clk) begin
        if (latch_c) begin
            addr_q  <= addr_i;
            wdata_q <= data_i;
            f3_q    <= funct3_i;
            store_q <= memwren_i;
        end
    end

    dmem_array #(
        .MEM_BYTES (MEM_BYTES),
        .OFFW      (OFFW)
    ) u_array (
        .clk     (clk),
        .off     (off_c),
        .we      (we_c),
        .wdata   (wdata_q[31:0]),
        .rdata_c (rdata_c)
    );

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: vector table plus reset-abort and throughput sequences.
module tb_dmem_lsu;

    localparam int unsigned LAT = 3;
    localparam logic [31:0] B   = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        memren_i;
    logic        memwren_i;
    logic [2:0]  funct3_i;
    logic        resp_valid_o;
    logic [31:0] data_o;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_lsu #(
        .AWIDTH    (32),
        .DWIDTH    (32),
        .BASE_ADDR (B),
        .MEM_BYTES (1048576),
        .LATENCY   (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .memren_i     (memren_i),
        .memwren_i    (memwren_i),
        .funct3_i     (funct3_i),
        .resp_valid_o (resp_valid_o),
        .data_o       (data_o),
        .misalign_o   (misalign_o)
    );

    typedef struct {
        logic        st;
        logic        both;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        exp_mis;
    } vec_t;

    vec_t vt[$];

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic both, input logic [2:0] f3,
                       input logic [31:0] off, input logic [31:0] wdata,
                       input logic [31:0] exp, input logic exp_mis);
        vec_t v;
        v.st = st; v.both = both; v.f3 = f3; v.addr = B + off;
        v.wdata = wdata; v.exp = exp; v.exp_mis = exp_mis;
        vt.push_back(v);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", idx), 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        memren_i    = !v.st || v.both;
        memwren_i   = v.st || v.both;
        funct3_i    = v.f3;
        addr_i      = v.addr;
        data_i      = v.wdata;
        @(posedge clk); #1;
        req_valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
        chk($sformatf("v%0d_ready_busy", idx), 32'(req_ready_o), 32'd0);
        lat = 0;
        while (!resp_valid_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(LAT));
        chk($sformatf("v%0d_data", idx), data_o, v.exp);
        chk($sformatf("v%0d_misalign", idx), 32'(misalign_o), 32'(v.exp_mis));
        @(posedge clk); #1;
        chk($sformatf("v%0d_resp_one_cycle", idx), 32'(resp_valid_o), 32'd0);
        chk($sformatf("v%0d_ready_back", idx), 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        int resp_cnt;
        int resp_cyc[$];
        vec_t v;

        rst = 1'b1; req_valid_i = 1'b0; memren_i = 1'b0; memwren_i = 1'b0;
        funct3_i = 3'b0; addr_i = '0; data_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_resp", 32'(resp_valid_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_mis", 32'(misalign_o), 32'd0);

        // st both f3 off wdata exp mis
        add(1, 0, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        add(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        add(1, 0, 3'b010, 32'h00, 32'h4433_2211, 32'h0, 0);
        add(1, 0, 3'b010, 32'h04, 32'h8877_6655, 32'h0, 0);
        add(1, 0, 3'b000, 32'h03, 32'h1234_5680, 32'h0, 0);
        add(0, 0, 3'b000, 32'h03, 32'h0, 32'hFFFF_FF80, 0);
        add(0, 0, 3'b100, 32'h03, 32'h0, 32'h0000_0080, 0);
        add(0, 0, 3'b010, 32'h00, 32'h0, 32'h8033_2211, 0);
        add(1, 0, 3'b001, 32'h06, 32'hABCD_8001, 32'h0, 0);
        add(0, 0, 3'b001, 32'h06, 32'h0, 32'hFFFF_8001, 0);
        add(0, 0, 3'b101, 32'h06, 32'h0, 32'h0000_8001, 0);
        add(0, 0, 3'b010, 32'h04, 32'h0, 32'h8001_6655, 0);
        add(0, 0, 3'b011, 32'h00, 32'h0, 32'h0, 0);
        add(1, 0, 3'b011, 32'h00, 32'hFFFF_FFFF, 32'h0, 0);
        add(0, 0, 3'b010, 32'h00, 32'h0, 32'h8033_2211, 0);
        add(0, 0, 3'b000, 32'h01, 32'h0, 32'h0000_0022, 0);
        add(0, 0, 3'b001, 32'h00, 32'h0, 32'h0000_2211, 0);
        add(1, 1, 3'b000, 32'h11, 32'h0000_005A, 32'h0, 0);
        add(0, 0, 3'b100, 32'h11, 32'h0, 32'h0000_005A, 0);
        add(0, 0, 3'b010, 32'h0010_0010, 32'h0, 32'hDEAD_5AEF, 0);
        add(0, 0, 3'b010, 32'h02, 32'h0, TRAP ? 32'h0 : 32'h6655_8033, TRAP);
        add(1, 0, 3'b010, 32'h02, 32'hCAFE_F00D, 32'h0, TRAP);
        add(0, 0, 3'b010, 32'h00, 32'h0, TRAP ? 32'h8033_2211 : 32'hF00D_2211, 0);
        add(0, 0, 3'b010, 32'h04, 32'h0, TRAP ? 32'h8001_6655 : 32'h8001_CAFE, 0);
        add(0, 0, 3'b001, 32'h01, 32'h0, TRAP ? 32'h0 : 32'h0000_0D22, TRAP);
        add(1, 0, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            run_vec(i, vt[i]);
        end

        // Reset during the final BUSY cycle abandons the store.
        @(negedge clk);
        req_valid_i = 1'b1; memwren_i = 1'b1; memren_i = 1'b0;
        funct3_i = 3'b010; addr_i = B + 32'h20; data_i = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid_i = 1'b0; memwren_i = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 32'(req_ready_o), 32'd1);
        chk("abort_resp", 32'(resp_valid_o), 32'd0);
        resp_cnt = 0;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (resp_valid_o) resp_cnt++;
        end
        chk("abort_no_resp", 32'(resp_cnt), 32'd0);
        v.st = 0; v.both = 0; v.f3 = 3'b010; v.addr = B + 32'h20; v.wdata = 0;
        v.exp = 32'h1122_3344; v.exp_mis = 0;
        run_vec(100, v);

        // Request with no enable is ignored.
        @(negedge clk);
        req_valid_i = 1'b1; memren_i = 1'b0; memwren_i = 1'b0;
        resp_cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid_o || !req_ready_o) resp_cnt++;
        end
        req_valid_i = 1'b0;
        chk("noen_ignored", 32'(resp_cnt), 32'd0);

        // Continuously presented loads are taken once per LAT+2 cycles.
        @(negedge clk);
        req_valid_i = 1'b1; memren_i = 1'b1; funct3_i = 3'b010; addr_i = B + 32'h20;
        for (int c = 1; c <= 4 * (LAT + 2) + 2; c++) begin
            @(posedge clk); #1;
            if (resp_valid_o) resp_cyc.push_back(c);
        end
        req_valid_i = 1'b0; memren_i = 1'b0;
        chk("b2b_count", 32'(resp_cyc.size()), 32'd4);
        if (resp_cyc.size() == 4) begin
            chk("b2b_first", 32'(resp_cyc[0]), 32'(LAT + 1));
            for (int k = 1; k < 4; k++) begin
                chk($sformatf("b2b_gap%0d", k), 32'(resp_cyc[k] - resp_cyc[k-1]), 32'(LAT + 2));
            end
        end
        chk("b2b_data", data_o, 32'h1122_3344);
        repeat (LAT + 4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
